// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the alignment / legality helpers used by the controller.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_BYTES, S_RESP} state_e;

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b10:   return a == 2'b00;
      2'b01:   return !a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// CPU-side request/response interface and memory-port interface of the LSU.
// master is the initiator side of each link.
interface lsu_req_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

interface lsu_mem_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
  logic                  mem_wr_en;
  logic [2:0]            mem_funct3;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (output mem_wr_en, mem_funct3, mem_addr, mem_wr_data, input  mem_rd_data);
  modport slave  (input  mem_wr_en, mem_funct3, mem_addr, mem_wr_data, output mem_rd_data);
endinterface

// File: rtl/lsu_ctrl_load_extend.sv
// Sign/zero extension of an assembled load value from its top byte (1, 2 or 4 bytes).
module load_extend (
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);
  always_comb begin
    data_o = data_i;
    case (nbytes_i)
      3'd1:    data_o = {{24{data_i[7]  & ~unsigned_i}}, data_i[7:0]};
      3'd2:    data_o = {{16{data_i[15] & ~unsigned_i}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, aligned accesses go straight to
// memory, misaligned ones are split into byte accesses and reassembled.
module lsu_ctrl import lsu_pkg::*; #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  lsu_req_if.slave  cpu_io,
  lsu_mem_if.master mem_io
);
  state_e                state_q, state_d;
  logic                  we_q, we_d, err_q, err_d, split_q, split_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, buf_q, buf_d;
  logic [1:0]            cnt_q, cnt_d, cnt_nx, cnt_last;
  logic                  mem_we_q, mem_we_d;
  logic [2:0]            mem_f3_q, mem_f3_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d, ext;
  logic                  legal, aligned;
  logic [2:0]            nbytes;

  assign legal    = is_legal(cpu_io.req_we, cpu_io.req_funct3);
  assign aligned  = is_aligned(cpu_io.req_funct3, cpu_io.req_addr[1:0]);
  assign cnt_nx   = cnt_q + 2'd1;
  assign cnt_last = (f3_q[1:0] == 2'b10) ? 2'd3 : 2'd1;

  always_comb begin
    state_d = state_q;
    we_d = we_q; err_d = err_q; split_d = split_q; f3_d = f3_q;
    addr_d = addr_q; wdata_d = wdata_q; buf_d = buf_q; cnt_d = cnt_q;
    // memory port rests at a word read of address 0 whenever no access is in flight
    mem_we_d = 1'b0; mem_f3_d = F3_W; mem_addr_d = '0; mem_wdata_d = '0;
    case (state_q)
      S_IDLE: if (cpu_io.req_valid) begin
        we_d = cpu_io.req_we;     f3_d = cpu_io.req_funct3;
        addr_d = cpu_io.req_addr; wdata_d = cpu_io.req_wdata;
        buf_d = '0; cnt_d = '0; err_d = 1'b0; split_d = 1'b0;
        if (!legal || (!aligned && !ALLOW_MISALIGNED)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (aligned) begin
          state_d     = S_ACCESS;
          mem_we_d    = cpu_io.req_we;
          mem_f3_d    = cpu_io.req_funct3;
          mem_addr_d  = cpu_io.req_addr;
          mem_wdata_d = cpu_io.req_wdata;
        end else begin
          state_d     = S_BYTES;
          split_d     = 1'b1;
          mem_we_d    = cpu_io.req_we;
          mem_f3_d    = cpu_io.req_we ? F3_B : F3_BU;
          mem_addr_d  = cpu_io.req_addr;
          mem_wdata_d = DATA_WIDTH'(cpu_io.req_wdata[7:0]);
        end
      end
      S_ACCESS: begin
        if (!we_q) buf_d = mem_io.mem_rd_data;
        state_d = S_RESP;
      end
      S_BYTES: begin
        if (!we_q) buf_d[{cnt_q, 3'b000} +: 8] = mem_io.mem_rd_data[7:0];
        if (cnt_q == cnt_last) begin
          state_d = S_RESP;
        end else begin
          cnt_d       = cnt_nx;
          mem_we_d    = we_q;
          mem_f3_d    = mem_f3_q;
          mem_addr_d  = addr_q + ADDR_WIDTH'(cnt_nx);
          mem_wdata_d = DATA_WIDTH'(wdata_q[{cnt_nx, 3'b000} +: 8]);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q <= 1'b0; err_q <= 1'b0; split_q <= 1'b0; f3_q <= '0;
      addr_q <= '0; wdata_q <= '0; buf_q <= '0; cnt_q <= '0;
      mem_we_q <= 1'b0; mem_f3_q <= F3_W; mem_addr_q <= '0; mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d; err_q <= err_d; split_q <= split_d; f3_q <= f3_d;
      addr_q <= addr_d; wdata_q <= wdata_d; buf_q <= buf_d; cnt_q <= cnt_d;
      mem_we_q <= mem_we_d; mem_f3_q <= mem_f3_d;
      mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
    end
  end

  // aligned loads arrive already extended by memory, so only split halfwords need work
  assign nbytes = (split_q && f3_q[1:0] == 2'b01) ? 3'd2 : 3'd4;

  load_extend u_ext (.data_i(buf_q), .nbytes_i(nbytes), .unsigned_i(f3_q[2]), .data_o(ext));

  assign cpu_io.req_ready  = (state_q == S_IDLE);
  assign cpu_io.resp_valid = (state_q == S_RESP);
  assign cpu_io.resp_err   = (state_q == S_RESP) && err_q;
  assign cpu_io.resp_rdata = ((state_q == S_RESP) && !we_q && !err_q) ? ext : '0;

  assign mem_io.mem_wr_en   = mem_we_q;
  assign mem_io.mem_funct3  = mem_f3_q;
  assign mem_io.mem_addr    = mem_addr_q;
  assign mem_io.mem_wr_data = mem_wdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: one DUT with misaligned splitting, one without,
// a byte-array memory behind the first and a constant-zero memory behind the second.
module tb_lsu_ctrl;
  logic clk, rst_n;
  logic v_valid, v_we, sel;
  logic [2:0]  v_f3;
  logic [31:0] v_addr, v_wdata;

  lsu_req_if r0(); lsu_req_if r1();
  lsu_mem_if m0(); lsu_mem_if m1();

  lsu_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .cpu_io(r0), .mem_io(m0));
  lsu_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .cpu_io(r1), .mem_io(m1));

  assign r0.req_valid = v_valid & ~sel;
  assign r1.req_valid = v_valid & sel;
  assign r0.req_we = v_we;       assign r1.req_we = v_we;
  assign r0.req_funct3 = v_f3;   assign r1.req_funct3 = v_f3;
  assign r0.req_addr = v_addr;   assign r1.req_addr = v_addr;
  assign r0.req_wdata = v_wdata; assign r1.req_wdata = v_wdata;
  assign m1.mem_rd_data = 32'h0;

  logic        o_ready, o_valid, o_err, o_mwe;
  logic [31:0] o_rdata, o_maddr, o_mwd;
  logic [2:0]  o_mf3;
  assign o_ready = sel ? r1.req_ready  : r0.req_ready;
  assign o_valid = sel ? r1.resp_valid : r0.resp_valid;
  assign o_err   = sel ? r1.resp_err   : r0.resp_err;
  assign o_rdata = sel ? r1.resp_rdata : r0.resp_rdata;
  assign o_mwe   = sel ? m1.mem_wr_en  : m0.mem_wr_en;
  assign o_mf3   = sel ? m1.mem_funct3 : m0.mem_funct3;
  assign o_maddr = sel ? m1.mem_addr   : m0.mem_addr;
  assign o_mwd   = sel ? m1.mem_wr_data : m0.mem_wr_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // byte memory (256 bytes, address aliased) doing its own load extension
  logic [7:0] mem [256];
  logic [7:0] ia, b0, b1, b2, b3;
  always_comb begin
    ia = m0.mem_addr[7:0];
    b0 = mem[ia]; b1 = mem[ia + 8'd1]; b2 = mem[ia + 8'd2]; b3 = mem[ia + 8'd3];
    case (m0.mem_funct3)
      3'b000:  m0.mem_rd_data = {{24{b0[7]}}, b0};
      3'b001:  m0.mem_rd_data = {{16{b1[7]}}, b1, b0};
      3'b010:  m0.mem_rd_data = {b3, b2, b1, b0};
      3'b100:  m0.mem_rd_data = {24'h0, b0};
      3'b101:  m0.mem_rd_data = {16'h0, b1, b0};
      default: m0.mem_rd_data = 32'h0;
    endcase
  end
  always @(posedge clk) begin
    if (m0.mem_wr_en) begin
      mem[ia] <= m0.mem_wr_data[7:0];
      if (m0.mem_funct3 != 3'b000) mem[ia + 8'd1] <= m0.mem_wr_data[15:8];
      if (m0.mem_funct3 == 3'b010) begin
        mem[ia + 8'd2] <= m0.mem_wr_data[23:16];
        mem[ia + 8'd3] <= m0.mem_wr_data[31:24];
      end
    end
  end

  int n_chk, n_fail;
  int res_lat, tr_n;
  logic        res_err, res_ready;
  logic [31:0] res_rdata;
  logic [31:0] tr_addr [8];
  logic [2:0]  tr_f3   [8];
  logic [7:0]  tr_data [8];
  logic [31:0] tr_wd   [8];

  // Issue one request, record every write pulse, latency in edges from acceptance.
  task automatic issue(input logic s, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    int guard;
    sel = s; guard = 0;
    @(negedge clk);
    while (!o_ready && guard < 20) begin @(negedge clk); guard++; end
    v_valid = 1'b1; v_we = we; v_f3 = f3; v_addr = a; v_wdata = d;
    @(posedge clk); #1;
    v_valid = 1'b0;
    res_lat = 1; tr_n = 0;
    while (!o_valid && res_lat < 12) begin
      if (o_mwe && tr_n < 8) begin
        tr_addr[tr_n] = o_maddr; tr_f3[tr_n] = o_mf3;
        tr_data[tr_n] = o_mwd[7:0]; tr_wd[tr_n] = o_mwd; tr_n++;
      end
      @(posedge clk); #1;
      res_lat++;
    end
    if (!o_valid) begin
      n_chk++; n_fail++;
      $display("FAIL resp_timeout addr=%h got no resp_valid within %0d cycles", a, res_lat);
    end
    res_rdata = o_rdata; res_err = o_err; res_ready = o_ready;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    n_chk++; if (o_ready !== 1'b1)        begin n_fail++; $display("FAIL rst_ready got %b exp 1", o_ready); end
    n_chk++; if (o_valid !== 1'b0)        begin n_fail++; $display("FAIL rst_resp_valid got %b exp 0", o_valid); end
    n_chk++; if (o_rdata !== 32'h0)       begin n_fail++; $display("FAIL rst_rdata got %h exp 0", o_rdata); end
    n_chk++; if (o_err !== 1'b0)          begin n_fail++; $display("FAIL rst_err got %b exp 0", o_err); end
    n_chk++; if (o_mwe !== 1'b0)          begin n_fail++; $display("FAIL rst_wr_en got %b exp 0", o_mwe); end
    n_chk++; if (o_mf3 !== 3'b010)        begin n_fail++; $display("FAIL rst_funct3 got %b exp 010", o_mf3); end
    n_chk++; if (o_maddr !== 32'h0)       begin n_fail++; $display("FAIL rst_addr got %h exp 0", o_maddr); end
    n_chk++; if (o_mwd !== 32'h0)         begin n_fail++; $display("FAIL rst_wdata got %h exp 0", o_mwd); end
    n_chk++; if (r1.req_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_ready_nomis got %b exp 1", r1.req_ready); end
  endtask

  task automatic test_aligned();
    issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    n_chk++; if (res_lat !== 2)       begin n_fail++; $display("FAIL sw_lat got %0d exp 2", res_lat); end
    n_chk++; if (tr_n !== 1)          begin n_fail++; $display("FAIL sw_pulses got %0d exp 1", tr_n); end
    n_chk++; if (tr_addr[0] !== 32'h10 || tr_f3[0] !== 3'b010 || tr_wd[0] !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL sw_bus got a=%h f=%b d=%h exp a=10 f=010 d=deadbeef", tr_addr[0], tr_f3[0], tr_wd[0]); end
    n_chk++; if (res_err !== 1'b0 || res_rdata !== 32'h0)
      begin n_fail++; $display("FAIL sw_resp got err=%b rd=%h exp err=0 rd=0", res_err, res_rdata); end
    n_chk++; if (res_ready !== 1'b0)  begin n_fail++; $display("FAIL resp_ready got %b exp 0", res_ready); end
    issue(0, 0, 3'b010, 32'h10, 32'h0);
    n_chk++; if (res_lat !== 2)       begin n_fail++; $display("FAIL lw_lat got %0d exp 2", res_lat); end
    n_chk++; if (res_rdata !== 32'hDEADBEEF || res_err !== 1'b0)
      begin n_fail++; $display("FAIL lw_rdata got %h err=%b exp deadbeef err=0", res_rdata, res_err); end
    n_chk++; if (tr_n !== 0)          begin n_fail++; $display("FAIL lw_pulses got %0d exp 0", tr_n); end
  endtask

  task automatic test_extend();
    issue(0, 1, 3'b010, 32'h20, 32'h000080FF);
    issue(0, 0, 3'b000, 32'h20, 32'h0);
    n_chk++; if (res_rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL lb got %h exp ffffffff", res_rdata); end
    issue(0, 0, 3'b100, 32'h21, 32'h0);
    n_chk++; if (res_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu got %h exp 00000080", res_rdata); end
    issue(0, 0, 3'b001, 32'h20, 32'h0);
    n_chk++; if (res_rdata !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh got %h exp ffff80ff", res_rdata); end
    issue(0, 0, 3'b101, 32'h20, 32'h0);
    n_chk++; if (res_rdata !== 32'h000080FF) begin n_fail++; $display("FAIL lhu got %h exp 000080ff", res_rdata); end
  endtask

  task automatic test_misaligned();
    logic [7:0] eb [4];
    eb[0] = 8'h44; eb[1] = 8'h33; eb[2] = 8'h22; eb[3] = 8'h11;
    issue(0, 1, 3'b010, 32'h13, 32'h11223344);
    n_chk++; if (res_lat !== 5) begin n_fail++; $display("FAIL msw_lat got %0d exp 5", res_lat); end
    n_chk++;
    if (tr_n !== 4) begin n_fail++; $display("FAIL msw_pulses got %0d exp 4", tr_n); end
    else for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (tr_addr[k] !== 32'h13 + k || tr_f3[k] !== 3'b000 || tr_data[k] !== eb[k]) begin
        n_fail++;
        $display("FAIL msw_byte%0d got a=%h f=%b d=%h exp a=%h f=000 d=%h", k, tr_addr[k], tr_f3[k], tr_data[k], 32'h13 + k, eb[k]);
      end
    end
    issue(0, 0, 3'b010, 32'h13, 32'h0);
    n_chk++; if (res_lat !== 5 || res_rdata !== 32'h11223344)
      begin n_fail++; $display("FAIL mlw got %h lat %0d exp 11223344 lat 5", res_rdata, res_lat); end
    issue(0, 1, 3'b000, 32'h07, 32'h34);
    issue(0, 1, 3'b000, 32'h08, 32'h92);
    issue(0, 0, 3'b001, 32'h07, 32'h0);
    n_chk++; if (res_lat !== 3 || res_rdata !== 32'hFFFF9234)
      begin n_fail++; $display("FAIL mlh got %h lat %0d exp ffff9234 lat 3", res_rdata, res_lat); end
    issue(0, 0, 3'b101, 32'h07, 32'h0);
    n_chk++; if (res_rdata !== 32'h00009234) begin n_fail++; $display("FAIL mlhu got %h exp 00009234", res_rdata); end
  endtask

  task automatic test_wrap();
    issue(0, 1, 3'b010, 32'hFFFFFFFE, 32'h55667788);
    n_chk++; if (tr_n !== 4 || tr_addr[1] !== 32'hFFFFFFFF || tr_addr[2] !== 32'h0 || tr_addr[3] !== 32'h1)
      begin n_fail++; $display("FAIL wrap_addr got n=%0d %h %h %h exp 4 ffffffff 0 1", tr_n, tr_addr[1], tr_addr[2], tr_addr[3]); end
    issue(0, 0, 3'b010, 32'hFFFFFFFE, 32'h0);
    n_chk++; if (res_rdata !== 32'h55667788) begin n_fail++; $display("FAIL wrap_lw got %h exp 55667788", res_rdata); end
  endtask

  task automatic test_illegal();
    issue(0, 0, 3'b011, 32'h40, 32'h0);
    n_chk++; if (res_err !== 1'b1 || res_lat !== 1 || tr_n !== 0 || res_rdata !== 32'h0)
      begin n_fail++; $display("FAIL ill_load got err=%b lat=%0d wr=%0d rd=%h exp 1 1 0 0", res_err, res_lat, tr_n, res_rdata); end
    issue(0, 1, 3'b100, 32'h40, 32'hFFFFFFFF);
    n_chk++; if (res_err !== 1'b1 || res_lat !== 1 || tr_n !== 0)
      begin n_fail++; $display("FAIL ill_store got err=%b lat=%0d wr=%0d exp 1 1 0", res_err, res_lat, tr_n); end
    issue(1, 0, 3'b010, 32'h2, 32'h0);
    n_chk++; if (res_err !== 1'b1 || res_lat !== 1 || tr_n !== 0)
      begin n_fail++; $display("FAIL nomis_lw got err=%b lat=%0d wr=%0d exp 1 1 0", res_err, res_lat, tr_n); end
    issue(1, 1, 3'b001, 32'h1, 32'hABCD);
    n_chk++; if (res_err !== 1'b1 || res_lat !== 1 || tr_n !== 0)
      begin n_fail++; $display("FAIL nomis_sh got err=%b lat=%0d wr=%0d exp 1 1 0", res_err, res_lat, tr_n); end
    issue(1, 0, 3'b010, 32'h4, 32'h0);
    n_chk++; if (res_err !== 1'b0 || res_lat !== 2)
      begin n_fail++; $display("FAIL nomis_aligned got err=%b lat=%0d exp 0 2", res_err, res_lat); end
  endtask

  task automatic test_back_to_back();
    int acc [4];
    int na;
    na = 0; sel = 1'b0;
    @(negedge clk);
    v_valid = 1'b1; v_we = 1'b0; v_f3 = 3'b010; v_addr = 32'h20;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (o_ready && na < 4) begin acc[na] = c; na++; end
    end
    v_valid = 1'b0;
    n_chk++; if (na !== 3 || acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3)
      begin n_fail++; $display("FAIL b2b_spacing got n=%0d at %0d %0d %0d exp 3 at 0 3 6", na, acc[0], acc[1], acc[2]); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(0, 1, 3'b000, 32'h31, 32'h00);
    issue(0, 1, 3'b000, 32'h32, 32'hA5);
    sel = 1'b0;
    @(negedge clk);
    while (!o_ready) @(negedge clk);
    v_valid = 1'b1; v_we = 1'b1; v_f3 = 3'b010; v_addr = 32'h31; v_wdata = 32'h11223344;
    @(posedge clk); #1; v_valid = 1'b0;
    @(posedge clk); #2;
    n_chk++; if (o_maddr !== 32'h32 || o_mwe !== 1'b1)
      begin n_fail++; $display("FAIL mid_k1 got a=%h we=%b exp 32 1", o_maddr, o_mwe); end
    rst_n = 1'b0; #1;
    n_chk++; if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_mwe !== 1'b0 || o_mf3 !== 3'b010 || o_maddr !== 32'h0 || o_mwd !== 32'h0)
      begin n_fail++; $display("FAIL mid_rst got rdy=%b v=%b we=%b f=%b a=%h d=%h exp 1 0 0 010 0 0", o_ready, o_valid, o_mwe, o_mf3, o_maddr, o_mwd); end
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (o_valid) seen++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (o_valid) seen++; end
    n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_resp got %0d resp pulses exp 0", seen); end
    issue(0, 0, 3'b100, 32'h31, 32'h0);
    n_chk++; if (res_rdata !== 32'h44) begin n_fail++; $display("FAIL mid_b31 got %h exp 00000044", res_rdata); end
    issue(0, 0, 3'b100, 32'h32, 32'h0);
    n_chk++; if (res_rdata !== 32'hA5) begin n_fail++; $display("FAIL mid_b32 got %h exp 000000a5", res_rdata); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; sel = 1'b0; v_valid = 1'b0; v_we = 1'b0;
    v_f3 = 3'b0; v_addr = 32'h0; v_wdata = 32'h0;
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_reset();
    test_aligned();
    test_extend();
    test_misaligned();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
